// File: rtl/ahb_bridge_byte_sequencer_if.sv
// Request/peripheral bundle for the byte sequencer: AHB-side capture signals
// plus the 8-bit APB-style peripheral channel.
interface ahb_bridge_byte_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              START;
    logic              WRITE;
    logic [ADDR_W-1:0] ADDR;
    logic [31:0]       WDATA;
    logic [3:0]        SIGNAL_LENGTH;
    logic              BUSY;
    logic              DONE;
    logic              ERROR;
    logic [31:0]       RDATA;
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [7:0]        PWDATA;
    logic [7:0]        PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output START, WRITE, ADDR, WDATA, SIGNAL_LENGTH, PRDATA, PREADY, PSLVERR,
        input  BUSY, DONE, ERROR, RDATA, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        input  START, WRITE, ADDR, WDATA, SIGNAL_LENGTH, PRDATA, PREADY, PSLVERR,
        output BUSY, DONE, ERROR, RDATA, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/ahb_bridge_byte_sequencer.sv
// Splits one captured AHB transfer (1/2/4 bytes) into sequential 8-bit
// peripheral accesses and reassembles read bytes into a 32-bit word.
module ahb_bridge_byte_sequencer #(
    parameter int ADDR_W = 32
) (
    input logic HCLK,
    input logic HRESETn,
    ahb_bridge_byte_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              write_q;
    logic [1:0]        last_q;
    logic [1:0]        k_q;
    logic [1:0]        k_d;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [7:0]        pwdata_q;
    logic              pwrite_q;
    logic              psel_q;
    logic              penable_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    // Illegal lengths collapse to a single byte; stored as the last byte index.
    function automatic logic [1:0] last_idx(input logic [3:0] len);
        case (len)
            4'd2:    return 2'd1;
            4'd4:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    assign k_d = k_q + 2'd1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            last_q    <= '0;
            k_q       <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        state_q   <= S_SETUP;
                        addr_q    <= bus.ADDR;
                        wdata_q   <= bus.WDATA;
                        write_q   <= bus.WRITE;
                        last_q    <= last_idx(bus.SIGNAL_LENGTH);
                        k_q       <= '0;
                        err_q     <= 1'b0;
                        rdata_q   <= '0;
                        paddr_q   <= bus.ADDR;
                        pwrite_q  <= bus.WRITE;
                        pwdata_q  <= bus.WRITE ? bus.WDATA[7:0] : 8'h00;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                S_SETUP: begin
                    state_q   <= S_ACCESS;
                    penable_q <= 1'b1;
                end
                S_ACCESS: begin
                    if (bus.PREADY) begin
                        penable_q <= 1'b0;
                        if (!write_q)
                            rdata_q[{k_q, 3'b000} +: 8] <= bus.PRDATA;
                        if (bus.PSLVERR || k_q == last_q) begin
                            state_q <= S_DONE;
                            psel_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= err_q | bus.PSLVERR;
                            error_q <= err_q | bus.PSLVERR;
                        end else begin
                            state_q  <= S_SETUP;
                            k_q      <= k_d;
                            paddr_q  <= addr_q + ADDR_W'(k_d);
                            pwdata_q <= write_q ? wdata_q[{k_d, 3'b000} +: 8] : 8'h00;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.ERROR   = error_q;
    assign bus.RDATA   = rdata_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;
endmodule

// File: tb/tb_ahb_bridge_byte_sequencer.sv
// Directed plus randomized transfers against a transfer-level model of the
// expected byte accesses, completion cycle, error flag and assembled word.
module tb_ahb_bridge_byte_sequencer;
    logic HCLK = 1'b0;
    logic HRESETn;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 HCLK = ~HCLK;

    ahb_bridge_byte_sequencer_if #(.ADDR_W(32)) bus();

    ahb_bridge_byte_sequencer #(.ADDR_W(32)) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // wt holds a 2-bit wait-state count per byte; err_byte<0 means no error;
    // rst_byte>=0 pulls reset during the access phase of that byte.
    task automatic run(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] len, input int err_byte, input logic [7:0] wt,
                       input logic [31:0] rd, input bit noise, input int rst_byte);
        int n, nacc, exp_cyc, cyc, acc, wl;
        bit exp_err, done_seen;
        logic [31:0] exp_rd;
        n = (len == 4'd1 || len == 4'd2 || len == 4'd4) ? int'(len) : 1;
        exp_err = (err_byte >= 0 && err_byte < n);
        nacc = exp_err ? err_byte + 1 : n;
        exp_rd = 32'h0;
        exp_cyc = 2 * nacc + 1;
        for (int i = 0; i < nacc; i++) begin
            if (!wr) exp_rd[8*i +: 8] = rd[8*i +: 8];
            exp_cyc += int'(wt[2*i +: 2]);
        end

        @(negedge HCLK);
        bus.START = 1'b1; bus.WRITE = wr; bus.ADDR = addr;
        bus.WDATA = wdata; bus.SIGNAL_LENGTH = len;
        @(posedge HCLK);
        cyc = 0; acc = 0; wl = int'(wt[1:0]); done_seen = 0;
        while (!done_seen && cyc < 200) begin
            @(negedge HCLK);
            cyc++;
            if (noise) begin
                bus.START = 1'($urandom); bus.WRITE = 1'($urandom);
                bus.ADDR = $urandom; bus.WDATA = $urandom;
                bus.SIGNAL_LENGTH = 4'($urandom);
            end else begin
                bus.START = 1'b0;
            end
            bus.PREADY = 1'($urandom); bus.PSLVERR = 1'($urandom); bus.PRDATA = 8'($urandom);
            chk("busy", 32'(bus.BUSY), 32'd1);
            if (bus.PSEL && bus.PENABLE) begin
                if (acc >= nacc) begin
                    chk("extra_access", acc, nacc);
                end else begin
                    chk("paddr", bus.PADDR, addr + 32'(acc));
                    chk("pwrite", 32'(bus.PWRITE), 32'(wr));
                    chk("pwdata", 32'(bus.PWDATA), wr ? 32'(wdata[8*acc +: 8]) : 32'h0);
                end
                if (rst_byte == acc) begin
                    HRESETn = 1'b0;
                    #1;
                    chk("rst_psel", 32'(bus.PSEL), 32'd0);
                    chk("rst_penable", 32'(bus.PENABLE), 32'd0);
                    chk("rst_busy", 32'(bus.BUSY), 32'd0);
                    chk("rst_rdata", bus.RDATA, 32'h0);
                    bus.START = 1'b0; bus.PREADY = 1'b0;
                    repeat (3) begin
                        @(negedge HCLK);
                        chk("rst_no_done", 32'(bus.DONE), 32'd0);
                    end
                    HRESETn = 1'b1;
                    return;
                end
                if (wl > 0) begin
                    bus.PREADY = 1'b0;
                    wl--;
                end else begin
                    bus.PREADY = 1'b1;
                    bus.PRDATA = rd[8*acc +: 8];
                    bus.PSLVERR = (acc == err_byte);
                    acc++;
                    wl = (acc < 4) ? int'(wt[2*acc +: 2]) : 0;
                end
            end
            if (bus.DONE) begin
                done_seen = 1;
                bus.START = 1'b0;
                chk("done_cycle", cyc, exp_cyc);
                chk("error", 32'(bus.ERROR), 32'(exp_err));
                chk("accesses", acc, nacc);
                if (!wr) chk("rdata", bus.RDATA, exp_rd);
            end
        end
        if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
        @(negedge HCLK);
        chk("idle_busy", 32'(bus.BUSY), 32'd0);
        chk("idle_psel", 32'(bus.PSEL), 32'd0);
        chk("idle_done", 32'(bus.DONE), 32'd0);
        if (!wr) chk("rdata_hold", bus.RDATA, exp_rd);
    endtask

    initial begin
        HRESETn = 1'b0;
        bus.START = 1'b0; bus.WRITE = 1'b0; bus.ADDR = '0; bus.WDATA = '0;
        bus.SIGNAL_LENGTH = '0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        #12;
        chk("reset_psel", 32'(bus.PSEL), 32'd0);
        chk("reset_penable", 32'(bus.PENABLE), 32'd0);
        chk("reset_busy", 32'(bus.BUSY), 32'd0);
        chk("reset_done", 32'(bus.DONE), 32'd0);
        chk("reset_error", 32'(bus.ERROR), 32'd0);
        chk("reset_rdata", bus.RDATA, 32'h0);
        chk("reset_paddr", bus.PADDR, 32'h0);
        chk("reset_pwdata", 32'(bus.PWDATA), 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        run(1'b1, 32'h100, 32'hA1B2C3D4, 4'd4, -1, 8'h00, 32'h0, 1'b0, -1);
        run(1'b0, 32'h20, 32'h0, 4'd2, -1, 8'h01, 32'h0000_3C5A, 1'b0, -1);
        run(1'b1, 32'h40, 32'h11223344, 4'b0011, -1, 8'h00, 32'h0, 1'b0, -1);
        run(1'b0, 32'h60, 32'h0, 4'd4, 1, 8'h00, 32'h9988_8877, 1'b0, -1);
        run(1'b1, 32'hFFFF_FFFF, 32'hCAFE_BEEF, 4'd2, -1, 8'h00, 32'h0, 1'b1, -1);
        run(1'b0, 32'h80, 32'h0, 4'd4, -1, 8'h00, 32'h4433_2211, 1'b0, 1);
        run(1'b1, 32'h200, 32'h5566_7788, 4'd4, -1, 8'h00, 32'h0, 1'b0, -1);

        for (int t = 0; t < 40; t++) begin
            logic [3:0] len;
            int eb;
            case ($urandom_range(0, 4))
                0: len = 4'd1;
                1: len = 4'd2;
                2, 3: len = 4'd4;
                default: len = 4'($urandom);
            endcase
            eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            run(1'($urandom), $urandom, $urandom, len, eb,
                8'($urandom) & 8'h55, $urandom, 1'($urandom), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
